// File: rtl/serial_adder_pkg.sv
// -----------------------------------------------------------------------------
// serial_adder_pkg
// Shared types and helpers for the bit-serial adder.
//   state_e    : control FSM states (IDLE, RUN, DONE), 2-bit encoding
//   cnt_width  : width of the bit counter for a given operand width
// -----------------------------------------------------------------------------
package serial_adder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  // Counter only has to reach WIDTH-1, so $clog2(WIDTH) bits suffice.
  // Clamped to 1 so the counter never collapses to zero width.
  function automatic int cnt_width(input int w);
    return (w <= 2) ? 1 : $clog2(w);
  endfunction

endpackage

// File: rtl/Full_Adder.sv
// -----------------------------------------------------------------------------
// Full_Adder
// Single-bit full-adder cell.
//   a, b, cin : addend bits and carry-in
//   s         : sum bit
//   cout      : carry-out
// -----------------------------------------------------------------------------
module Full_Adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);

  assign s    = a ^ b ^ cin;
  assign cout = (a & b) | (a & cin) | (b & cin);

endmodule

// File: rtl/serial_adder.sv
// -----------------------------------------------------------------------------
// serial_adder
// Bit-serial two-operand adder: one full-adder cell plus a registered carry,
// one bit per clock, LSB first. Operands arrive on a valid/ready handshake and
// the result (sum, carry-out, signed overflow) leaves on a second one.
//   clk, rst_n          : clock (rising edge), asynchronous active-low reset
//   in_valid/in_ready   : operand handshake
//   in_a, in_b, in_cin  : operands and carry-in, sampled on the accepting edge
//   out_valid/out_ready : result handshake
//   out_sum             : A+B+cin modulo 2^WIDTH
//   out_cout            : carry out of bit WIDTH-1
//   out_ovf             : signed overflow (carry into MSB ^ carry out of MSB)
// -----------------------------------------------------------------------------
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_cout,
  output logic             out_ovf
);

  localparam int CNT_W = cnt_width(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0] CNT_PREMSB = CNT_W'(WIDTH - 2);

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   a_sr_q, a_sr_d;
  logic [WIDTH-1:0]   b_sr_q, b_sr_d;
  logic [WIDTH-1:0]   sum_sr_q, sum_sr_d;
  logic               carry_q, carry_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               ovf_c_q, ovf_c_d;
  logic [WIDTH-1:0]   out_sum_q, out_sum_d;
  logic               out_cout_q, out_cout_d;
  logic               out_ovf_q, out_ovf_d;

  logic fa_s;
  logic fa_co;

  Full_Adder u_fa (
    .a    (a_sr_q[0]),
    .b    (b_sr_q[0]),
    .cin  (carry_q),
    .s    (fa_s),
    .cout (fa_co)
  );

  // in_ready is gated by rst_n so nothing can be offered a handshake while
  // the block is held in reset.
  assign in_ready  = rst_n && (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign out_sum   = out_sum_q;
  assign out_cout  = out_cout_q;
  assign out_ovf   = out_ovf_q;

  always_comb begin
    state_d    = state_q;
    a_sr_d     = a_sr_q;
    b_sr_d     = b_sr_q;
    sum_sr_d   = sum_sr_q;
    carry_d    = carry_q;
    cnt_d      = cnt_q;
    ovf_c_d    = ovf_c_q;
    out_sum_d  = out_sum_q;
    out_cout_d = out_cout_q;
    out_ovf_d  = out_ovf_q;

    case (state_q)
      IDLE: begin
        if (in_valid && in_ready) begin
          a_sr_d  = in_a;
          b_sr_d  = in_b;
          carry_d = in_cin;
          cnt_d   = '0;
          state_d = RUN;
        end
      end

      RUN: begin
        // Sum bits enter at the MSB and move down, so after WIDTH shifts
        // bit 0 of the result sits at sum_sr[0].
        sum_sr_d = {fa_s, sum_sr_q[WIDTH-1:1]};
        a_sr_d   = a_sr_q >> 1;
        b_sr_d   = b_sr_q >> 1;
        carry_d  = fa_co;

        // Carry produced by bit WIDTH-2 is the carry into the MSB.
        if (cnt_q == CNT_PREMSB) begin
          ovf_c_d = fa_co;
        end

        if (cnt_q == CNT_LAST) begin
          state_d    = DONE;
          out_sum_d  = {fa_s, sum_sr_q[WIDTH-1:1]};
          out_cout_d = fa_co;
          out_ovf_d  = ovf_c_q ^ fa_co;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      DONE: begin
        // Result registers are left untouched here and after the handshake;
        // only out_valid drops when the state returns to IDLE.
        if (out_ready) begin
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      a_sr_q     <= '0;
      b_sr_q     <= '0;
      sum_sr_q   <= '0;
      carry_q    <= 1'b0;
      cnt_q      <= '0;
      ovf_c_q    <= 1'b0;
      out_sum_q  <= '0;
      out_cout_q <= 1'b0;
      out_ovf_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      a_sr_q     <= a_sr_d;
      b_sr_q     <= b_sr_d;
      sum_sr_q   <= sum_sr_d;
      carry_q    <= carry_d;
      cnt_q      <= cnt_d;
      ovf_c_q    <= ovf_c_d;
      out_sum_q  <= out_sum_d;
      out_cout_q <= out_cout_d;
      out_ovf_q  <= out_ovf_d;
    end
  end

endmodule

// File: tb/tb_serial_adder.sv
// -----------------------------------------------------------------------------
// tb_serial_adder
// Directed and random checks of serial_adder at WIDTH=8: arithmetic results,
// latency, backpressure, ignored operands outside IDLE and asynchronous reset.
// -----------------------------------------------------------------------------
module tb_serial_adder;

  localparam int W = 8;

  logic         clk;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_a;
  logic [W-1:0] in_b;
  logic         in_cin;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_sum;
  logic         out_cout;
  logic         out_ovf;

  int errors = 0;
  int checks = 0;

  serial_adder #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_cin    (in_cin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
    .out_cout  (out_cout),
    .out_ovf   (out_ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One complete operation: accept, measure latency, check the result,
  // optionally stall the output for 'stall' cycles, then consume it.
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic c,
                        input logic [W-1:0] es, input logic ec, input logic eo,
                        input int stall, input string tag);
    int n;
    n = 0;
    while (!in_ready && n < 50) begin
      tick();
      n++;
    end
    check({tag, " in_ready"}, {31'd0, in_ready}, 32'd1);
    in_a      = a;
    in_b      = b;
    in_cin    = c;
    in_valid  = 1'b1;
    out_ready = (stall == 0);
    tick();
    // Scramble the inputs after acceptance; they must have no effect.
    in_valid = 1'b0;
    in_a     = ~a;
    in_b     = ~b;
    in_cin   = ~c;
    n = 0;
    while (!out_valid && n < 40) begin
      tick();
      n++;
    end
    check({tag, " latency"}, n, W);
    check({tag, " sum"}, {24'd0, out_sum}, {24'd0, es});
    check({tag, " cout"}, {31'd0, out_cout}, {31'd0, ec});
    check({tag, " ovf"}, {31'd0, out_ovf}, {31'd0, eo});
    for (int i = 0; i < stall; i++) begin
      tick();
      check({tag, " stall valid"}, {31'd0, out_valid}, 32'd1);
      check({tag, " stall sum"}, {24'd0, out_sum}, {24'd0, es});
    end
    out_ready = 1'b1;
    tick();
    check({tag, " valid drop"}, {31'd0, out_valid}, 32'd0);
    out_ready = 1'b0;
  endtask

  initial begin
    logic [W-1:0] ra;
    logic [W-1:0] rb;
    logic         rc;
    logic [W:0]   full;
    logic         rovf;

    rst_n     = 1'b1;
    in_valid  = 1'b0;
    in_a      = '0;
    in_b      = '0;
    in_cin    = 1'b0;
    out_ready = 1'b0;

    // Reset state
    #2 rst_n = 1'b0;
    #2;
    check("rst in_ready", {31'd0, in_ready}, 32'd0);
    check("rst out_valid", {31'd0, out_valid}, 32'd0);
    check("rst out_sum", {24'd0, out_sum}, 32'd0);
    check("rst out_cout", {31'd0, out_cout}, 32'd0);
    check("rst out_ovf", {31'd0, out_ovf}, 32'd0);
    tick();
    tick();
    #2 rst_n = 1'b1;
    tick();
    check("post-rst in_ready", {31'd0, in_ready}, 32'd1);

    // Directed arithmetic
    run_op(8'h5A, 8'h3C, 1'b0, 8'h96, 1'b0, 1'b1, 0, "5A+3C");
    run_op(8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0, 0, "FF+01");
    run_op(8'hFF, 8'h00, 1'b1, 8'h00, 1'b1, 1'b0, 0, "FF+00+1");
    run_op(8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1, 0, "80+80");
    run_op(8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1, 0, "7F+01");

    // Backpressure with new operands offered while the result waits
    in_a      = 8'h12;
    in_b      = 8'h34;
    in_cin    = 1'b0;
    in_valid  = 1'b1;
    out_ready = 1'b0;
    tick();
    in_valid = 1'b0;
    repeat (W) tick();
    check("bp valid", {31'd0, out_valid}, 32'd1);
    check("bp sum", {24'd0, out_sum}, 32'h46);
    in_a     = 8'hFF;
    in_b     = 8'hFF;
    in_cin   = 1'b1;
    in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("bp hold valid", {31'd0, out_valid}, 32'd1);
      check("bp hold sum", {24'd0, out_sum}, 32'h46);
      check("bp in_ready", {31'd0, in_ready}, 32'd0);
    end
    out_ready = 1'b1;
    in_valid  = 1'b0;
    tick();
    out_ready = 1'b0;
    check("bp released valid", {31'd0, out_valid}, 32'd0);
    check("bp idle in_ready", {31'd0, in_ready}, 32'd1);
    check("bp sum kept", {24'd0, out_sum}, 32'h46);
    run_op(8'h20, 8'h22, 1'b0, 8'h42, 1'b0, 1'b0, 0, "after-bp");

    // Asynchronous reset in the middle of RUN
    in_a     = 8'h55;
    in_b     = 8'h0F;
    in_cin   = 1'b0;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    tick();
    #2 rst_n = 1'b0;
    #1;
    check("midrst out_valid", {31'd0, out_valid}, 32'd0);
    check("midrst out_sum", {24'd0, out_sum}, 32'd0);
    check("midrst out_cout", {31'd0, out_cout}, 32'd0);
    check("midrst out_ovf", {31'd0, out_ovf}, 32'd0);
    check("midrst in_ready", {31'd0, in_ready}, 32'd0);
    tick();
    check("midrst held in_ready", {31'd0, in_ready}, 32'd0);
    check("midrst held valid", {31'd0, out_valid}, 32'd0);
    #2 rst_n = 1'b1;
    tick();
    run_op(8'h01, 8'h02, 1'b0, 8'h03, 1'b0, 1'b0, 0, "01+02");

    // Random regression against an arithmetic reference
    for (int k = 0; k < 1000; k++) begin
      ra   = 8'($urandom_range(255));
      rb   = 8'($urandom_range(255));
      rc   = 1'($urandom_range(1));
      full = {1'b0, ra} + {1'b0, rb} + {8'd0, rc};
      rovf = (ra[W-1] == rb[W-1]) && (full[W-1] != ra[W-1]);
      run_op(ra, rb, rc, full[W-1:0], full[W], rovf, int'($urandom_range(3)), "rand");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/serial_adder.md
Name: serial_adder

Overview:
- Bit-serial two-operand adder built around a single full-adder cell and a registered carry.
- Accepts WIDTH-bit operands over a valid/ready handshake and processes one bit per clock, LSB first.
- Presents the sum, carry-out and signed overflow on a second valid/ready handshake.
- Area-minimal alternative to the ripple/lookahead adders, for datapaths that can tolerate WIDTH-cycle latency.

Parameters:
- WIDTH, 16, operand/sum width in bits; legal range WIDTH >= 2.

Ports:
- clk  input  1  single clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  operands valid.
- in_ready  output  1  block can accept operands.
- in_a  input  WIDTH  operand A.
- in_b  input  WIDTH  operand B.
- in_cin  input  1  carry-in into bit 0.
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts result.
- out_sum  output  WIDTH  A+B+cin modulo 2^WIDTH.
- out_cout  output  1  carry out of bit WIDTH-1.
- out_ovf  output  1  signed overflow (carry into MSB XOR carry out of MSB).

Behaviour:
- Reset is asynchronous and active-low:
  - rst_n low forces state IDLE and clears a_sr, b_sr, sum_sr, carry, cnt, ovf_c.
  - out_valid=0; out_sum=0; out_cout=0; out_ovf=0.
  - in_ready is gated to 0 while rst_n is low.
- The FSM has three states: IDLE, RUN, DONE.
- IDLE:
  - in_ready=1 and out_valid=0.
  - On in_valid&&in_ready: a_sr<=in_a, b_sr<=in_b, carry<=in_cin, cnt<=0; go to RUN.
- RUN (in_ready=0, out_valid=0), on each rising edge:
  - The full-adder cell computes (a_sr[0], b_sr[0], carry) -> (s, co).
  - sum_sr<={s, sum_sr[WIDTH-1:1]}; a_sr and b_sr shift right by 1; carry<=co; cnt<=cnt+1.
  - When cnt==WIDTH-2, ovf_c<=co, capturing the carry into the MSB.
  - When cnt==WIDTH-1 this is the last bit: go to DONE. out_sum, out_cout and out_ovf are registered from the final sum_sr, co and ovf_c^co.
- DONE:
  - out_valid=1 and in_ready=0.
  - Outputs are held stable while out_ready=0.
  - On out_valid&&out_ready, go to IDLE.
- Latency: out_valid rises exactly WIDTH rising edges after the accepting edge.
- Back-to-back throughput is one operation per WIDTH+2 cycles.
- in_valid is ignored outside IDLE; operands presented during RUN or DONE are not captured.
- After the output handshake, out_sum, out_cout and out_ovf keep their last value. Only out_valid drops.
- A reset during RUN or DONE aborts the operation. No partial result is emitted, and the next accepted operation computes correctly.
- cnt width is $clog2(WIDTH). The counter never wraps because RUN exits at WIDTH-1.
- in_a, in_b and in_cin are sampled only on the accepting edge. Later changes have no effect.

Decomposition:
- Package serial_adder_pkg holds:
  - the state enum typedef (IDLE, RUN, DONE), 2-bit encoding;
  - a localparam helper for the counter width.
- Sub-module: exactly one instance of the existing Full_Adder cell (a, b, cin -> s, cout) in the datapath. No other sub-modules.
- Control, counter and shift registers stay in serial_adder.

Test Plan (WIDTH=8):
- 0x5A + 0x3C, cin=0, out_ready=1 -> out_sum=0x96, out_cout=0, out_ovf=1; out_valid rises exactly 8 edges after acceptance.
- 0xFF + 0x01, cin=0 -> out_sum=0x00, out_cout=1, out_ovf=0. Then 0xFF + 0x00 with cin=1 -> 0x00, cout=1, ovf=0.
- 0x80 + 0x80, cin=0 -> out_sum=0x00, out_cout=1, out_ovf=1. Then 0x7F + 0x01 -> 0x80, cout=0, ovf=1.
- Backpressure: 0x12 + 0x34, out_ready held 0 for 5 cycles in DONE, with a new in_valid driven meanwhile:
  - out_valid=1 and out_sum=0x46 stable throughout;
  - in_ready=0 and the new operands are ignored;
  - after the handshake, IDLE is reached and the next operand pair is accepted.
- Reset mid-RUN: assert rst_n=0 asynchronously after 3 RUN cycles:
  - all outputs read 0 immediately and in_ready=0 during reset;
  - after release, 0x01 + 0x02 -> 0x03 with correct latency.
- Random regression: 1000 random in_a/in_b/in_cin with random out_ready stalls -> every result matches the reference model (A+B+cin, signed overflow); no dropped or duplicated transactions.
